// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the multiply/divide unit: MDCtrl opcodes,
// MD FSM state encoding and the default datapath width.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; gives |x| on entry and applies the
// result sign in FIX.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding HI/LO: shift-add multiply and
// restoring divide, one bit per cycle, sharing a single adder/subtractor.
module md_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] MD_In_1,
  input  logic [WIDTH-1:0] MD_In_2,
  input  logic [2:0]       MDCtrl,
  input  logic             MD_Start,
  input  logic             MD_Flush,
  output logic             MD_Busy,
  output logic             MD_Done,
  output logic [WIDTH-1:0] HI_Out,
  output logic [WIDTH-1:0] LO_Out
);

  md_state_e state, state_nxt;

  logic [WIDTH-1:0] acc, mplr, opb, hi, lo;
  logic [CNT_W-1:0] count;
  logic             op_div, neg_q, neg_r, done;

  logic             is_signed, is_div_req, is_md, div_zero, accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]   op_a, op_b;
  logic [WIDTH+1:0] sum;

  assign is_signed  = (MDCtrl == MD_MULT) || (MDCtrl == MD_DIV);
  assign is_div_req = (MDCtrl == MD_DIV) || (MDCtrl == MD_DIVU);
  assign is_md      = (MDCtrl <= MD_DIVU);
  assign div_zero   = is_div_req && (MD_In_2 == '0);
  assign a_neg      = is_signed & MD_In_1[WIDTH-1];
  assign b_neg      = is_signed & MD_In_2[WIDTH-1];
  // Flush wins over a same-cycle start, so nothing is accepted while flushing.
  assign accept     = (state == MD_IDLE) && MD_Start && !MD_Flush;

  md_sign_fix #(.W(WIDTH))   u_abs_a (.val(MD_In_1), .neg(a_neg), .res(abs_a));
  md_sign_fix #(.W(WIDTH))   u_abs_b (.val(MD_In_2), .neg(b_neg), .res(abs_b));
  md_sign_fix #(.W(2*WIDTH)) u_prod  (.val({acc, mplr}), .neg(neg_q), .res(prod_fix));
  md_sign_fix #(.W(WIDTH))   u_quo   (.val(mplr), .neg(neg_q), .res(quo_fix));
  md_sign_fix #(.W(WIDTH))   u_rem   (.val(acc),  .neg(neg_r), .res(rem_fix));

  // Multiply adds the multiplicand; divide subtracts the divisor from the
  // shifted partial remainder, carry-out meaning "no borrow".
  always_comb begin
    op_a = op_div ? {acc, mplr[WIDTH-1]} : {1'b0, acc};
    op_b = op_div ? ~{1'b0, opb} : {1'b0, opb};
    sum  = {1'b0, op_a} + {1'b0, op_b} + {{(WIDTH+1){1'b0}}, op_div};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept && is_md) state_nxt = div_zero ? MD_FIX : MD_CALC;
      MD_CALC: begin
        if (MD_Flush)                           state_nxt = MD_IDLE;
        else if (count == CNT_W'(WIDTH - 1))    state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= MD_IDLE;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mplr   <= '0;
      opb    <= '0;
      count  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            if (MDCtrl == MD_MTHI) hi <= MD_In_1;
            if (MDCtrl == MD_MTLO) lo <= MD_In_1;
            if (is_md) begin
              op_div <= is_div_req;
              count  <= '0;
              // Divide-by-zero preloads the final HI/LO image and skips CALC.
              if (div_zero) begin
                acc   <= MD_In_1;
                mplr  <= '1;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
              end else begin
                acc   <= '0;
                opb   <= is_div_req ? abs_b : abs_a;
                mplr  <= is_div_req ? abs_a : abs_b;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
              end
            end
          end
        end
        MD_CALC: begin
          if (!MD_Flush) begin
            count <= count + CNT_W'(1);
            if (op_div) begin
              acc  <= sum[WIDTH+1] ? sum[WIDTH-1:0] : {acc[WIDTH-2:0], mplr[WIDTH-1]};
              mplr <= {mplr[WIDTH-2:0], sum[WIDTH+1]};
            end else if (mplr[0]) begin
              {acc, mplr} <= {sum[WIDTH:0], mplr[WIDTH-1:1]};
            end else begin
              {acc, mplr} <= {1'b0, acc, mplr[WIDTH-1:1]};
            end
          end
        end
        MD_FIX: begin
          if (!MD_Flush) begin
            if (op_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign MD_Busy = (state != MD_IDLE);
  assign MD_Done = done;
  assign HI_Out  = hi;
  assign LO_Out  = lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table of mult/div results plus
// hand-written sequences for MTHI/MTLO, start-while-busy, flush and reset.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_1 = '0, in_2 = '0;
  logic [2:0]  ctrl = '0;
  logic        start = 1'b0, flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int n_total = 0;
  int n_pass  = 0;

  md_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset_n), .MD_In_1(in_1), .MD_In_2(in_2),
    .MDCtrl(ctrl), .MD_Start(start), .MD_Flush(flush),
    .MD_Busy(busy), .MD_Done(done), .HI_Out(hi_out), .LO_Out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for Done; returns results and latency.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output int lat, output logic busy_at_start,
                        output logic busy_at_done, output logic done_after);
    ctrl = op; in_1 = a; in_2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    busy_at_start = busy;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    r_hi = hi_out;
    r_lo = lo_out;
    busy_at_done = busy;
    tick();
    done_after = done;
  endtask

  initial begin
    logic [31:0] r_hi, r_lo;
    int          lat;
    logic        b0, bd, da, seen;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
    vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4]  = '{3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 33};
    vecs[7]  = '{3'd0, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 33};
    vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[9]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
    vecs[10] = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33};

    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, lat, b0, bd, da);
      chk($sformatf("v%0d_hi", i), r_hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), r_lo, vecs[i].exp_lo);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy_start", i), {31'd0, b0}, 32'd1);
      chk($sformatf("v%0d_busy_done", i), {31'd0, bd}, 32'd0);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, da}, 32'd0);
    end

    // MTHI then MTLO back to back: no busy, values visible after each edge.
    seen = 1'b0;
    ctrl = 3'd4; in_1 = 32'h1234; start = 1'b1;
    tick();
    seen |= busy;
    chk("mthi_hi", hi_out, 32'h1234);
    ctrl = 3'd5; in_1 = 32'h5678;
    tick();
    seen |= busy;
    start = 1'b0;
    chk("mtlo_lo", lo_out, 32'h5678);
    chk("mtlo_hi_kept", hi_out, 32'h1234);
    tick();
    seen |= busy;
    chk("mt_no_busy", {31'd0, seen}, 32'd0);

    // Flush in IDLE suppresses a same-cycle start.
    ctrl = 3'd4; in_1 = 32'h99; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    tick();
    chk("idle_flush_hi", hi_out, 32'h1234);

    // MULTU 2x3 with an ignored start while busy.
    ctrl = 3'd1; in_1 = 32'd2; in_2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    ctrl = 3'd1; in_1 = 32'd9; in_2 = 32'd9; start = 1'b1;
    tick();
    start = 1'b0; in_1 = '0; in_2 = '0;
    lat = 6;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("busy_start_lo", lo_out, 32'd6);
    chk("busy_start_hi", hi_out, 32'd0);
    chk("busy_start_lat", lat, 33);
    tick();

    // Flush at cycle 10 of a DIVU with HI/LO preloaded to 0xA/0xB.
    ctrl = 3'd4; in_1 = 32'hA; start = 1'b1;
    tick();
    ctrl = 3'd5; in_1 = 32'hB;
    tick();
    ctrl = 3'd3; in_1 = 32'd1000; in_2 = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= done | busy;
    end
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    chk("flush_hi", hi_out, 32'hA);
    chk("flush_lo", lo_out, 32'hB);

    // Reset at cycle 20 of a MULT, then a fresh MULTU 4x4.
    ctrl = 3'd0; in_1 = 32'd12345; in_2 = 32'hFFFFFF00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset_n = 1'b0;
    tick();
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi_out, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);
    run_op(3'd1, 32'd4, 32'd4, r_hi, r_lo, lat, b0, bd, da);
    chk("post_rst_lo", r_lo, 32'd16);
    chk("post_rst_hi", r_hi, 32'd0);
    chk("post_rst_lat", lat, 33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
